// File: rtl/phase_clk_gen_pkg.sv
// Shared types and legal parameter ranges for the phase clock generator.
package phase_clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  localparam int NPH_MIN   = 2;
  localparam int NPH_MAX   = 8;
  localparam int CNT_W_MIN = 2;

endpackage

// File: rtl/phase_clk_gen_timer.sv
// Loadable down-counter used to time both the ACTIVE and GAP intervals.
// Loading value N gives N+1 cycles before the counter reaches zero.
// last_o flags the final cycle of the interval that is running now.
// last_next_o is the same flag one cycle early, so the parent can
// register outputs that must line up with that final cycle.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o,
  output logic             last_next_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load takes priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o      = (cnt_q == '0);
  assign last_next_o = (cnt_d == '0);

endmodule

// File: rtl/phase_clk_gen.sv
// Non-overlapping multi-phase clock generator.
// Each phase is max(period,1) active cycles followed by gap dead cycles.
// period and gap are captured at the start of every sequence.
// All outputs come straight from flops. Their next values are decoded
// from the next state, so no output is combinational from the inputs.
module phase_clk_gen
  import phase_clk_gen_pkg::*;
#(
  parameter int NPH   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] gap,
  output logic [NPH-1:0]   ph,
  output logic [NPH-1:0]   ph_start,
  output logic             cycle_done,
  output logic             running
);

  localparam int IDX_W = (NPH > 1) ? $clog2(NPH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPH - 1);

  if (NPH < NPH_MIN || NPH > NPH_MAX || CNT_W < CNT_W_MIN) begin : g_param_err
    $error("phase_clk_gen: NPH must be 2..8 and CNT_W at least 2");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] period_l_q, period_l_d;
  logic [CNT_W-1:0] gap_l_q, gap_l_d;
  logic [NPH-1:0]   ph_q, ph_d;
  logic [NPH-1:0]   ph_start_q, ph_start_d;
  logic             cycle_done_q, cycle_done_d;
  logic             running_q, running_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_last;
  logic             tmr_last_next;
  logic             phase_end;
  logic             start_seq;
  logic             enter_active;
  logic [CNT_W-1:0] period_eff_in;
  logic [CNT_W-1:0] period_eff_l;

  assign period_eff_in = (period == '0) ? CNT_W'(1) : period;
  assign period_eff_l  = (period_l_q == '0) ? CNT_W'(1) : period_l_q;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .last_o      (tmr_last),
    .last_next_o (tmr_last_next)
  );

  // Next-state logic: sequence phases, time intervals, latch controls at sequence start.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    period_l_d   = period_l_q;
    gap_l_d      = gap_l_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    phase_end    = 1'b0;
    start_seq    = 1'b0;
    enter_active = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          start_seq = 1'b1;
        end
      end
      ACTIVE: begin
        if (tmr_last) begin
          if (gap_l_q != '0) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = gap_l_q - CNT_W'(1);
          end else begin
            phase_end = 1'b1;
          end
        end
      end
      GAP: begin
        if (tmr_last) begin
          phase_end = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A finished phase either advances to the next one or closes the sequence.
    if (phase_end) begin
      if (idx_q != IDX_LAST) begin
        state_d      = ACTIVE;
        idx_d        = idx_q + IDX_W'(1);
        tmr_load     = 1'b1;
        tmr_val      = period_eff_l - CNT_W'(1);
        enter_active = 1'b1;
      end else if (en) begin
        start_seq = 1'b1;
      end else begin
        state_d  = IDLE;
        idx_d    = '0;
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
    end

    if (start_seq) begin
      state_d      = ACTIVE;
      idx_d        = '0;
      period_l_d   = period;
      gap_l_d      = gap;
      tmr_load     = 1'b1;
      tmr_val      = period_eff_in - CNT_W'(1);
      enter_active = 1'b1;
    end
  end

  // Output decode from the next state, so the registered outputs match the state they describe.
  always_comb begin
    ph_d         = '0;
    ph_start_d   = '0;
    cycle_done_d = 1'b0;
    running_d    = (state_d != IDLE);
    if (state_d == ACTIVE) begin
      ph_d = NPH'(1) << idx_d;
    end
    if (enter_active) begin
      ph_start_d = NPH'(1) << idx_d;
    end
    if (idx_d == IDX_LAST && tmr_last_next) begin
      if (state_d == GAP || (state_d == ACTIVE && gap_l_d == '0)) begin
        cycle_done_d = 1'b1;
      end
    end
  end

  // State, latched controls and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      period_l_q   <= '0;
      gap_l_q      <= '0;
      ph_q         <= '0;
      ph_start_q   <= '0;
      cycle_done_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      period_l_q   <= period_l_d;
      gap_l_q      <= gap_l_d;
      ph_q         <= ph_d;
      ph_start_q   <= ph_start_d;
      cycle_done_q <= cycle_done_d;
      running_q    <= running_d;
    end
  end

  assign ph         = ph_q;
  assign ph_start   = ph_start_q;
  assign cycle_done = cycle_done_q;
  assign running    = running_q;

endmodule

// File: tb/tb_phase_clk_gen.sv
// Bench for phase_clk_gen: a 2-phase and a 4-phase instance share stimulus.
// Each instance is checked every cycle against a queue-based model.
// The model expands every sequence into its full list of per-cycle outputs.
module tb_phase_clk_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] gap = 8'd0;

  logic [1:0] ph2, st2;
  logic       done2, run2;
  logic [3:0] ph4, st4;
  logic       done4, run4;

  always #5 clk = ~clk;

  phase_clk_gen #(.NPH(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .gap(gap),
    .ph(ph2), .ph_start(st2), .cycle_done(done2), .running(run2)
  );

  phase_clk_gen #(.NPH(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .gap(gap),
    .ph(ph4), .ph_start(st4), .cycle_done(done4), .running(run4)
  );

  typedef struct {
    logic [7:0] ph;
    logic [7:0] st;
    logic       done;
  } exp_t;

  exp_t       q2[$];
  exp_t       q4[$];
  logic [7:0] e_ph[2];
  logic [7:0] e_st[2];
  logic       e_done[2];
  logic       e_run[2];

  int n_checks = 0;
  int n_fail   = 0;
  int run_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expand one full sequence for an NPH-phase generator with the given controls.
  function automatic void fill(input int d, input int nph, input int p, input int g);
    exp_t e;
    int   pe;
    pe = (p == 0) ? 1 : p;
    for (int i = 0; i < nph; i++) begin
      for (int c = 0; c < pe; c++) begin
        e.ph   = 8'(1 << i);
        e.st   = (c == 0) ? 8'(1 << i) : 8'd0;
        e.done = (g == 0) && (i == nph - 1) && (c == pe - 1);
        if (d == 0) q2.push_back(e); else q4.push_back(e);
      end
      for (int c = 0; c < g; c++) begin
        e.ph   = 8'd0;
        e.st   = 8'd0;
        e.done = (i == nph - 1) && (c == g - 1);
        if (d == 0) q2.push_back(e); else q4.push_back(e);
      end
    end
  endfunction

  task automatic model_clear();
    q2.delete();
    q4.delete();
    for (int d = 0; d < 2; d++) begin
      e_ph[d] = 8'd0; e_st[d] = 8'd0; e_done[d] = 1'b0; e_run[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    exp_t e;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (q2.size() == 0 && en) fill(0, 2, int'(period), int'(gap));
      if (q4.size() == 0 && en) fill(1, 4, int'(period), int'(gap));
      if (q2.size() > 0) begin
        e = q2.pop_front();
        e_ph[0] = e.ph; e_st[0] = e.st; e_done[0] = e.done; e_run[0] = 1'b1;
      end else begin
        e_ph[0] = 8'd0; e_st[0] = 8'd0; e_done[0] = 1'b0; e_run[0] = 1'b0;
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        e_ph[1] = e.ph; e_st[1] = e.st; e_done[1] = e.done; e_run[1] = 1'b1;
      end else begin
        e_ph[1] = 8'd0; e_st[1] = 8'd0; e_done[1] = 1'b0; e_run[1] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "/ph2"},      32'(ph2),   32'(e_ph[0]));
    check_eq({tag, "/start2"},   32'(st2),   32'(e_st[0]));
    check_eq({tag, "/done2"},    32'(done2), 32'(e_done[0]));
    check_eq({tag, "/run2"},     32'(run2),  32'(e_run[0]));
    check_eq({tag, "/ph4"},      32'(ph4),   32'(e_ph[1]));
    check_eq({tag, "/start4"},   32'(st4),   32'(e_st[1]));
    check_eq({tag, "/done4"},    32'(done4), 32'(e_done[1]));
    check_eq({tag, "/run4"},     32'(run4),  32'(e_run[1]));
    check_eq({tag, "/onehot2"},  32'($countones(ph2) <= 1), 32'd1);
    check_eq({tag, "/onehot4"},  32'($countones(ph4) <= 1), 32'd1);
    if (run2) run_cnt++;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Drop en and let both sequences finish; bounded so a stuck DUT cannot hang the run.
  task automatic wait_idle(input string tag);
    en = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (q2.size() == 0 && q4.size() == 0) break;
      step(tag);
    end
    step(tag);
    check_eq({tag, "/idle_running"}, 32'(run2 | run4), 32'd0);
    check_eq({tag, "/idle_ph"},      32'({ph2, ph4}),  32'd0);
  endtask

  initial begin
    model_clear();
    #1 rst_n = 1'b0;
    run_n(3, "reset");
    check_eq("reset/ph2", 32'(ph2), 32'd0);
    check_eq("reset/ph4", 32'(ph4), 32'd0);
    rst_n = 1'b1;
    step("post_reset");

    // Basic run: 3 active + 1 dead per phase, en held high.
    period = 8'd3; gap = 8'd1; en = 1'b1;
    run_n(24, "basic");

    // Zero period and zero gap: single-cycle back-to-back phases.
    period = 8'd0; gap = 8'd0;
    run_n(24, "zero");
    wait_idle("zero_stop");

    // Mid-sequence stop: one cycle of en, sequence must still run to completion.
    period = 8'd5; gap = 8'd2; en = 1'b1;
    run_cnt = 0;
    step("stop");
    en = 1'b0;
    run_n(30, "stop");
    check_eq("stop/len2", 32'(run_cnt), 32'd14);
    wait_idle("stop_idle");

    // Reprogram during phase 1: current sequence keeps 3, next uses 6.
    period = 8'd3; gap = 8'd1; en = 1'b1;
    run_n(5, "reprog_a");
    period = 8'd6;
    run_n(40, "reprog_b");
    wait_idle("reprog_idle");

    // Asynchronous reset between edges while a phase is active.
    period = 8'd4; gap = 8'd1; en = 1'b1;
    run_n(7, "arst_pre");
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst/ph2_low", 32'(ph2), 32'd0);
    check_eq("arst/ph4_low", 32'(ph4), 32'd0);
    check_eq("arst/running", 32'(run2 | run4), 32'd0);
    model_clear();
    @(negedge clk);
    compare_all("arst_hold");
    rst_n = 1'b1;
    step("arst_restart");
    check_eq("arst/restart_ph2", 32'(ph2), 32'd1);
    run_n(20, "arst_post");
    wait_idle("arst_idle");

    // Maximum count values.
    period = 8'd255; gap = 8'd255; en = 1'b1;
    step("max");
    en = 1'b0;
    run_n(2100, "max");
    wait_idle("max_idle");

    // Randomised run with occasional en toggles and control changes.
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) begin
        period = 8'($urandom_range(0, 6));
        gap    = 8'($urandom_range(0, 3));
      end
      step("rand");
    end
    wait_idle("rand_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_clk_gen.md
PHASE_CLK_GEN -- requirements
Module: phase_clk_gen

Interface
REQ-001 Parameter NPH, default 2: number of non-overlapping phase outputs; legal range 2..8.
REQ-002 Parameter CNT_W, default 8: width of the period and gap controls.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  fast source clock (HFOSC domain); all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  run request; sampled every clk edge.
REQ-007 period  in  CNT_W  active cycles per phase; 0 is treated as 1.
REQ-008 gap  in  CNT_W  dead cycles after each phase; 0 is legal.
REQ-009 ph  out  NPH  phase clocks; bit i is phase i.
REQ-010 ph_start  out  NPH  one-cycle strobe in the first active cycle of phase i.
REQ-011 cycle_done  out  1  one-cycle pulse in the final cycle of a full NPH-phase sequence.
REQ-012 running  out  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACTIVE and GAP; it SHALL also hold a phase index idx (0..NPH-1) and a down-counter cnt.
REQ-014 IDLE with en=1 at edge k SHALL give ACTIVE, idx=0 from edge k+1, with ph[0]=1 and ph_start[0]=1 in that cycle.
REQ-015 On every entry to ACTIVE with idx=0, period and gap SHALL be latched; they SHALL stay constant for the whole sequence.
REQ-016 ACTIVE SHALL last exactly max(period_l,1) cycles with ph[idx]=1.
REQ-017 At the end of ACTIVE, the FSM SHALL go to GAP for gap_l cycles, with ph all zero; if gap_l=0, it SHALL go directly to the next phase.
REQ-018 At the end of a phase (after its GAP, or after ACTIVE when gap_l=0), if idx<NPH-1, the FSM SHALL give idx+1 and ACTIVE.
REQ-019 At the end of a phase with idx=NPH-1, cycle_done SHALL be 1 in that final cycle; the next state SHALL be ACTIVE with idx=0 (new latch) if en=1, else IDLE.
REQ-020 Deasserting en mid-sequence SHALL NOT truncate any phase: the sequence completes and stops per REQ-019 (stretch-safe stop).
REQ-021 At most one ph bit SHALL be high in any cycle, including when gap_l=0 (back-to-back phases).
REQ-022 All outputs SHALL be registered and glitch-free; no output SHALL depend combinationally on inputs.
REQ-023 One full sequence SHALL take exactly NPH*(max(period_l,1)+gap_l) cycles.
REQ-024 Changes to period or gap mid-sequence SHALL have no effect until the next idx=0 latch.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, idx=0, cnt=0, latched values=0, ph=0, ph_start=0, cycle_done=0, running=0.
REQ-026 Reset asserted mid-phase SHALL force ph low immediately; after release, the first phase SHALL start no earlier than one edge after en is sampled high.

Structure
REQ-027 Package phase_clk_gen_pkg SHALL hold the state enum (IDLE, ACTIVE, GAP) and the NPH legal-range constants.
REQ-028 One sub-module, phase_timer, SHALL implement the loadable CNT_W down-counter with a "last" flag; it SHALL be instantiated once.
REQ-029 Parameter checks SHALL stop elaboration for NPH outside 2..8 or CNT_W<2.

Verification
REQ-030 The bench SHALL cover a basic two-phase run: NPH=2, period=3, gap=1, en held high -> ph = 01,01,01,00,10,10,10,00 repeating; cycle_done on the 8th cycle; ph_start[0] on cycles 1 and 9.
REQ-031 The bench SHALL cover zero gap and zero period: period=0, gap=0, NPH=4 -> ph walks 0001,0010,0100,1000 one cycle each; cycle_done every 4th cycle; never two bits high.
REQ-032 The bench SHALL cover a mid-sequence stop: en dropped during phase 0 of period=5, gap=2 -> the sequence completes (14 cycles total), then IDLE with running=0 and ph=0.
REQ-033 The bench SHALL cover a mid-sequence reprogram: period 3->6 written during phase 1 -> the current sequence keeps 3-cycle phases; the next sequence uses 6.
REQ-034 The bench SHALL cover asynchronous reset: rst_n pulsed low mid-ACTIVE, between edges -> ph=0 before the next edge; restart with en=1 gives ph[0] one edge later.
REQ-035 The bench SHALL cover the maximum count: CNT_W=8, period=255, gap=255 -> each phase is 255 high and 255 dead cycles; the counter does not wrap early.
